// File: rtl/jt12_kon_pkg.sv
// Shared types and constants for the key-on write path.
// Optional macro JT12_KON_MERGE_EN enables tail-entry merging.
package jt12_kon_pkg;

   localparam logic [7:0] KON_ADDR  = 8'h28;
   localparam int         KON_SLOTS = 24;
   localparam int         OP_W      = 4;
   localparam int         CH_W      = 3;
   localparam int         CMD_W     = OP_W + CH_W;

   typedef struct packed {
      logic [OP_W-1:0] op;
      logic [CH_W-1:0] ch;
   } kon_cmd_t;

   typedef enum logic {
      IDLE,
      SERVE
   } kon_state_t;

   // codes 3 and 7 share the low bits 2'b11
   function automatic logic kon_ch_valid(input logic [CH_W-1:0] ch);
      return (ch[1:0] != 2'b11);
   endfunction

endpackage

// File: rtl/jt12_kon_fifo.sv
// Small synchronous FIFO of key-on commands.
// With JT12_KON_MERGE_EN the newest entry can be overwritten in place.
module jt12_kon_fifo
   import jt12_kon_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  logic     pop,
   input  kon_cmd_t din,
   output kon_cmd_t dout,
   output logic     empty,
   output logic     full,
`ifdef JT12_KON_MERGE_EN
   input  logic     ovr,
   output kon_cmd_t tail,
`endif
   output logic [AW:0] level
);

   localparam logic [AW-1:0] ONE    = AW'(1);
   localparam logic [AW:0]   FULL_L = (AW+1)'(DEPTH);

   kon_cmd_t        mem [DEPTH];
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [AW:0]     cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ONE;
         if (pop)  rd_ptr <= rd_ptr + ONE;
         cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end
   end

   // storage needs no reset: the pointers define what is valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
`ifdef JT12_KON_MERGE_EN
      end else if (ovr) begin
         mem[wr_ptr - ONE] <= din;
`endif
      end
   end

   assign dout  = mem[rd_ptr];
   assign empty = (cnt == '0);
   assign full  = (cnt == FULL_L);
   assign level = cnt;
`ifdef JT12_KON_MERGE_EN
   assign tail  = mem[wr_ptr - ONE];
`endif

endmodule

// File: rtl/jt12_kon_wr.sv
// Key-on register decoder: queues 0x28 writes and holds each one for a 24-slot round.
// Optional macro JT12_KON_MERGE_EN merges same-channel writes into the pending tail.
module jt12_kon_wr
   import jt12_kon_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic       cpu_wr,
   input  logic       cpu_a1,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_din,
   output logic [3:0] keyon_op,
   output logic [2:0] keyon_ch,
   output logic       up_keyon,
   output logic       busy,
   output logic       ovf
);

   localparam int          AW    = $clog2(DEPTH);
   localparam logic [4:0]  LAST  = 5'(KON_SLOTS - 1);
   localparam logic [AW:0] LVL_1 = (AW+1)'(1);

   kon_state_t  state, state_nxt;
   logic [4:0]  cnt, cnt_nxt;
   kon_cmd_t    cur, cur_nxt;
   kon_cmd_t    wr_cmd, head;
   logic        busy_nxt, ovf_nxt;
   logic        wr_hit, merge, push, pop;
   logic        empty, full;
   logic [AW:0] level, lvl_nxt;
   logic        unused_din3;

   assign unused_din3 = cpu_din[3];
   assign wr_cmd = '{op: cpu_din[7:4], ch: cpu_din[2:0]};
   assign wr_hit = cpu_wr && !cpu_a1 && (cpu_addr == KON_ADDR)
                   && kon_ch_valid(cpu_din[2:0]);
   assign pop    = clk_en && !empty && (state == IDLE || cnt == LAST);

`ifdef JT12_KON_MERGE_EN
   kon_cmd_t tail;
   // only merge into an entry that stays queued after this edge
   assign merge = wr_hit && !empty && !(pop && level == LVL_1)
                  && (tail.ch == wr_cmd.ch);
`else
   assign merge = 1'b0;
`endif

   assign push = wr_hit && !merge && (!full || pop);

   jt12_kon_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (wr_cmd),
      .dout  (head),
      .empty (empty),
      .full  (full),
`ifdef JT12_KON_MERGE_EN
      .ovr   (merge),
      .tail  (tail),
`endif
      .level (level)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cur_nxt   = cur;
      ovf_nxt   = ovf || (wr_hit && !merge && !push);
      case (state)
         IDLE: begin
            if (pop) begin
               state_nxt = SERVE;
               cnt_nxt   = '0;
               cur_nxt   = head;
            end
         end
         SERVE: begin
            if (clk_en) begin
               if (cnt != LAST) begin
                  cnt_nxt = cnt + 5'd1;
               end else if (pop) begin
                  cnt_nxt = '0;
                  cur_nxt = head;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      lvl_nxt  = level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      busy_nxt = (state_nxt == SERVE) || (lvl_nxt != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         cur   <= '0;
         busy  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         cur   <= cur_nxt;
         busy  <= busy_nxt;
         ovf   <= ovf_nxt;
      end
   end

   assign up_keyon = (state == SERVE);
   assign keyon_op = cur.op;
   assign keyon_ch = cur.ch;

endmodule
